// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the MIPS decode stage: opcodes, functs,
// ALU operations and the ID/EX latch payload.
package cpu_types_pkg;

    localparam int unsigned NREGS_DEFAULT  = 32;
    localparam int unsigned RA_REG_DEFAULT = 31;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned REG_AW         = 5;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b,
        OP_HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2a,
        FN_SLTU = 6'h2b
    } funct_t;

    // ALU_ADD is zero so bubbles and non-ALU instructions carry a neutral op.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    typedef struct packed {
        logic                valid;
        logic [WORD_W-1:0]   npc;
        logic [WORD_W-1:0]   rdat1;
        logic [WORD_W-1:0]   rdat2;
        logic [WORD_W-1:0]   imm32;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [REG_AW-1:0]   wsel;
        aluop_t              aluop;
        logic                alusrc;
        logic                regwen;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic                branch;
        logic                bne;
        logic                jump;
        logic                jr;
        logic                jal;
        logic                halt;
    } decode_latch_t;

    // Sign-extend a 16-bit immediate to a full word.
    function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-latch, writeback and ID/EX latch signals of the decode stage.
interface decode_stage_if;
    import cpu_types_pkg::*;

    logic                ihit;
    logic                stall_in;
    logic                flush;
    logic [WORD_W-1:0]   fl_instr;
    logic [WORD_W-1:0]   fl_npc;
    logic                fl_valid;
    logic                wb_wen;
    logic [REG_AW-1:0]   wb_sel;
    logic [WORD_W-1:0]   wb_data;
    logic                hazard;
    decode_latch_t       out;

    modport master (
        output ihit, stall_in, flush, fl_instr, fl_npc, fl_valid,
        output wb_wen, wb_sel, wb_data,
        input  hazard, out
    );

    modport slave (
        input  ihit, stall_in, flush, fl_instr, fl_npc, fl_valid,
        input  wb_wen, wb_sel, wb_data,
        output hazard, out
    );

endinterface

// File: rtl/register_file.sv
// NREGS x 32 register file, one write and two combinational read ports.
// r0 is hardwired to zero. Define FORWARD_WB_EN to bypass the write data
// onto a read port that addresses the register being written this cycle.
module register_file
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wen,
    input  logic [REG_AW-1:0]   i_wsel,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [REG_AW-1:0]   i_rsel1,
    input  logic [REG_AW-1:0]   i_rsel2,
    output logic [WORD_W-1:0]   o_rdat1,
    output logic [WORD_W-1:0]   o_rdat2
);

    logic [WORD_W-1:0] r_regs [NREGS];
    logic              w_wr;
    logic [WORD_W-1:0] w_arr1;
    logic [WORD_W-1:0] w_arr2;

    assign w_wr = i_wen & (i_wsel != '0);

    // Register storage; writes to r0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wsel] <= i_wdata;
        end
    end

    assign w_arr1 = (i_rsel1 == '0) ? '0 : r_regs[i_rsel1];
    assign w_arr2 = (i_rsel2 == '0) ? '0 : r_regs[i_rsel2];

`ifdef FORWARD_WB_EN
    assign o_rdat1 = (w_wr && (i_wsel == i_rsel1)) ? i_wdata : w_arr1;
    assign o_rdat2 = (w_wr && (i_wsel == i_rsel2)) ? i_wdata : w_arr2;
`else
    assign o_rdat1 = w_arr1;
    assign o_rdat2 = w_arr2;
`endif

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register read, control/immediate decode,
// load-use hazard detection and the ID/EX latch.
// Optional macro FORWARD_WB_EN enables writeback-to-decode bypass in the
// register file.
module decode_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned RA_REG = RA_REG_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    decode_stage_if.slave bus
);

    opcode_t             w_op;
    funct_t              w_fn;
    logic [REG_AW-1:0]   w_rs;
    logic [REG_AW-1:0]   w_rt;
    logic [REG_AW-1:0]   w_rd;
    logic [4:0]          w_shamt;
    logic [15:0]         w_imm16;
    logic [WORD_W-1:0]   w_rdat1;
    logic [WORD_W-1:0]   w_rdat2;
    logic                w_known;
    logic                w_reads_rt;
    logic                w_hazard;
    logic                w_en;
    decode_latch_t       w_dec;
    decode_latch_t       r_out;

    assign w_op    = opcode_t'(bus.fl_instr[31:26]);
    assign w_fn    = funct_t'(bus.fl_instr[5:0]);
    assign w_rs    = bus.fl_instr[25:21];
    assign w_rt    = bus.fl_instr[20:16];
    assign w_rd    = bus.fl_instr[15:11];
    assign w_shamt = bus.fl_instr[10:6];
    assign w_imm16 = bus.fl_instr[15:0];
    assign w_en    = bus.ihit & ~bus.stall_in;

    register_file #(.NREGS(NREGS)) u_rf (
        .clk     (CLK),
        .rst     (RST),
        .i_wen   (bus.wb_wen),
        .i_wsel  (bus.wb_sel),
        .i_wdata (bus.wb_data),
        .i_rsel1 (w_rs),
        .i_rsel2 (w_rt),
        .o_rdat1 (w_rdat1),
        .o_rdat2 (w_rdat2)
    );

    // Instructions whose rt field is a source operand.
    assign w_reads_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                        (w_op == OP_BNE)   || (w_op == OP_SW);

    // Load in ID/EX feeding a source of the instruction now in decode.
    assign w_hazard = r_out.valid & r_out.memread & (r_out.wsel != '0) &
                      bus.fl_valid &
                      ((r_out.wsel == w_rs) | ((r_out.wsel == w_rt) & w_reads_rt));

    // Control and immediate decode of the fetch-latch instruction.
    always_comb begin
        w_dec       = '0;
        w_known     = 1'b1;
        w_dec.npc   = bus.fl_npc;
        w_dec.rdat1 = w_rdat1;
        w_dec.rdat2 = w_rdat2;
        w_dec.rs    = w_rs;
        w_dec.rt    = w_rt;
        case (w_op)
            OP_RTYPE: begin
                w_dec.wsel   = w_rd;
                w_dec.regwen = 1'b1;
                w_dec.imm32  = 32'(w_shamt);
                case (w_fn)
                    FN_SLL:          w_dec.aluop = ALU_SLL;
                    FN_SRL:          w_dec.aluop = ALU_SRL;
                    FN_ADD, FN_ADDU: w_dec.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: w_dec.aluop = ALU_SUB;
                    FN_AND:          w_dec.aluop = ALU_AND;
                    FN_OR:           w_dec.aluop = ALU_OR;
                    FN_XOR:          w_dec.aluop = ALU_XOR;
                    FN_NOR:          w_dec.aluop = ALU_NOR;
                    FN_SLT:          w_dec.aluop = ALU_SLT;
                    FN_SLTU:         w_dec.aluop = ALU_SLTU;
                    FN_JR: begin
                        w_dec.jr     = 1'b1;
                        w_dec.wsel   = '0;
                        w_dec.regwen = 1'b0;
                    end
                    default:         w_known = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_dec.wsel   = w_rt;
                w_dec.regwen = 1'b1;
                w_dec.alusrc = 1'b1;
                w_dec.imm32  = sext16(w_imm16);
                w_dec.aluop  = (w_op == OP_SLTI)  ? ALU_SLT  :
                               (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_dec.wsel   = w_rt;
                w_dec.regwen = 1'b1;
                w_dec.alusrc = 1'b1;
                w_dec.imm32  = 32'(w_imm16);
                w_dec.aluop  = (w_op == OP_ANDI) ? ALU_AND :
                               (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                w_dec.wsel   = w_rt;
                w_dec.regwen = 1'b1;
                w_dec.alusrc = 1'b1;
                w_dec.imm32  = {w_imm16, 16'h0000};
                w_dec.aluop  = ALU_OR;
            end
            OP_LW: begin
                w_dec.wsel     = w_rt;
                w_dec.regwen   = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.memread  = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.imm32    = sext16(w_imm16);
            end
            OP_SW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memwrite = 1'b1;
                w_dec.imm32    = sext16(w_imm16);
            end
            OP_BEQ, OP_BNE: begin
                w_dec.branch = 1'b1;
                w_dec.bne    = (w_op == OP_BNE);
                w_dec.aluop  = ALU_SUB;
                w_dec.imm32  = sext16(w_imm16);
            end
            OP_J, OP_JAL: begin
                w_dec.jump  = 1'b1;
                w_dec.imm32 = 32'(bus.fl_instr[25:0]);
                if (w_op == OP_JAL) begin
                    w_dec.jal    = 1'b1;
                    w_dec.wsel   = REG_AW'(RA_REG);
                    w_dec.regwen = 1'b1;
                end
            end
            OP_HALT: begin
                w_dec.halt = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
        w_dec.regwen = w_dec.regwen & (w_dec.wsel != '0);
        w_dec.valid  = 1'b1;
        if (!(bus.fl_valid && w_known)) begin
            w_dec = '0;
        end
    end

    // ID/EX latch: reset, flush/hazard bubble, load, or hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= '0;
        end else if (w_en) begin
            if (bus.flush || w_hazard) begin
                r_out <= '0;
            end else begin
                r_out <= w_dec;
            end
        end
    end

    assign bus.out    = r_out;
    assign bus.hazard = w_hazard;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage with a behavioural model.
module tb_decode_stage;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if dif();

    decode_stage dut (
        .CLK (clk),
        .RST (rst),
        .bus (dif.slave)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    decode_latch_t exp_q[$];
    logic          exp_h_q[$];
    decode_latch_t m_out;
    logic [31:0]   m_rf [32];

    // Architectural decode of one instruction, straight from the ISA rules.
    function automatic decode_latch_t model_decode(input logic [31:0] ins, input logic [31:0] npc,
                                                   input logic [31:0] a, input logic [31:0] b);
        decode_latch_t d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [31:0] se;
        logic [31:0] ze;
        logic ok;
        logic wr;
        d  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        ok = 1'b1;
        wr = 1'b0;
        d.valid = 1'b1; d.npc = npc; d.rdat1 = a; d.rdat2 = b;
        d.rs = ins[25:21]; d.rt = ins[20:16];
        if (op == 6'h00) begin
            d.imm32 = {27'd0, ins[10:6]};
            d.wsel  = ins[15:11];
            wr      = 1'b1;
            case (fn)
                6'h00: d.aluop = ALU_SLL;
                6'h02: d.aluop = ALU_SRL;
                6'h20, 6'h21: d.aluop = ALU_ADD;
                6'h22, 6'h23: d.aluop = ALU_SUB;
                6'h24: d.aluop = ALU_AND;
                6'h25: d.aluop = ALU_OR;
                6'h26: d.aluop = ALU_XOR;
                6'h27: d.aluop = ALU_NOR;
                6'h2a: d.aluop = ALU_SLT;
                6'h2b: d.aluop = ALU_SLTU;
                6'h08: begin d.jr = 1'b1; d.wsel = 5'd0; wr = 1'b0; end
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: begin d.imm32 = se; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_ADD;  end
                6'h0a:        begin d.imm32 = se; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_SLT;  end
                6'h0b:        begin d.imm32 = se; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_SLTU; end
                6'h0c:        begin d.imm32 = ze; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_AND;  end
                6'h0d:        begin d.imm32 = ze; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_OR;   end
                6'h0e:        begin d.imm32 = ze; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_XOR;  end
                6'h0f:        begin d.imm32 = {ins[15:0], 16'h0}; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.aluop = ALU_OR; end
                6'h23:        begin d.imm32 = se; d.alusrc = 1; d.wsel = ins[20:16]; wr = 1; d.memread = 1; d.memtoreg = 1; end
                6'h2b:        begin d.imm32 = se; d.alusrc = 1; d.memwrite = 1; end
                6'h04:        begin d.imm32 = se; d.branch = 1; d.aluop = ALU_SUB; end
                6'h05:        begin d.imm32 = se; d.branch = 1; d.bne = 1; d.aluop = ALU_SUB; end
                6'h02:        begin d.imm32 = {6'd0, ins[25:0]}; d.jump = 1; end
                6'h03:        begin d.imm32 = {6'd0, ins[25:0]}; d.jump = 1; d.jal = 1; d.wsel = 5'd31; wr = 1; end
                6'h3f:        d.halt = 1'b1;
                default:      ok = 1'b0;
            endcase
        end
        d.regwen = wr && (d.wsel != 5'd0);
        if (!ok) d = '0;
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] sel, input logic ww,
                                               input logic [4:0] ws, input logic [31:0] wd);
        if (sel == 5'd0) return 32'd0;
`ifdef FORWARD_WB_EN
        if (ww && ws == sel) return wd;
`endif
        return m_rf[sel];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, advance the model, queue expectations.
    task automatic cyc(input logic r, input logic ih, input logic st, input logic fl, input logic fv,
                       input logic [31:0] ins, input logic ww, input logic [4:0] ws, input logic [31:0] wd);
        logic [31:0] npc;
        logic [5:0]  op;
        logic        rdrt;
        logic        haz;
        @(negedge clk);
        npc = $urandom;
        rst = r; dif.ihit = ih; dif.stall_in = st; dif.flush = fl; dif.fl_valid = fv;
        dif.fl_instr = ins; dif.fl_npc = npc;
        dif.wb_wen = ww; dif.wb_sel = ws; dif.wb_data = wd;
        #1;
        op   = ins[31:26];
        rdrt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
        haz  = m_out.valid && m_out.memread && (m_out.wsel != 5'd0) && fv &&
               ((m_out.wsel == ins[25:21]) || ((m_out.wsel == ins[20:16]) && rdrt));
        exp_h_q.push_back(haz);
        if (r) begin
            m_out = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (ih && !st) begin
                if (fl || haz) m_out = '0;
                else if (!fv) m_out = '0;
                else m_out = model_decode(ins, npc,
                                          model_read(ins[25:21], ww, ws, wd),
                                          model_read(ins[20:16], ww, ws, wd));
            end
            if (ww && ws != 5'd0) m_rf[ws] = wd;
        end
        exp_q.push_back(m_out);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] ins;
        case ($urandom_range(0, 19))
            0, 1, 2: op = 6'h00;
            3, 4, 5: op = 6'h23;
            6:  op = 6'h2b;  7:  op = 6'h04;  8:  op = 6'h05;  9:  op = 6'h09;
            10: op = 6'h08;  11: op = 6'h0a;  12: op = 6'h0b;  13: op = 6'h0c;
            14: op = 6'h0d;  15: op = 6'h0e;  16: op = 6'h0f;  17: op = 6'h02;
            18: op = 6'h03;  default: op = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'h3e;
        endcase
        case ($urandom_range(0, 13))
            0: fn = 6'h00; 1: fn = 6'h02; 2: fn = 6'h08; 3: fn = 6'h20; 4: fn = 6'h21;
            5: fn = 6'h22; 6: fn = 6'h23; 7: fn = 6'h24; 8: fn = 6'h25; 9: fn = 6'h26;
            10: fn = 6'h27; 11: fn = 6'h2a; 12: fn = 6'h2b; default: fn = 6'h3f;
        endcase
        ins = $urandom;
        ins[31:26] = op;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        if (op == 6'h00) begin
            ins[15:11] = 5'($urandom_range(0, 7));
            ins[5:0]   = fn;
        end
        return ins;
    endfunction

    // Monitor: hazard before each edge, latch contents after each edge.
    initial begin
        decode_latch_t e;
        logic          eh;
        forever begin
            @(negedge clk); #3;
            if (exp_h_q.size() > 0) begin
                eh = exp_h_q.pop_front();
                n_checks++;
                if (dif.hazard !== eh) begin
                    n_fail++;
                    $display("FAIL hazard: got %b expected %b", dif.hazard, eh);
                end
            end
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dif.out !== e) begin
                    n_fail++;
                    $display("FAIL latch: got %h expected %h", dif.out, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] i_addiu, i_lw, i_addu4, i_ori, i_addu6, i_addu7, fwd_exp;
        i_addiu = {6'h09, 5'd1, 5'd2, 16'hFFFF};
        i_lw    = {6'h23, 5'd1, 5'd3, 16'h0000};
        i_addu4 = {6'h00, 5'd3, 5'd2, 5'd4, 5'd0, 6'h21};
        i_ori   = {6'h0d, 5'd0, 5'd8, 16'h00F0};
        i_addu6 = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h21};
        i_addu7 = {6'h00, 5'd0, 5'd0, 5'd7, 5'd0, 6'h21};
        m_out = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        dif.ihit = 0; dif.stall_in = 0; dif.flush = 0; dif.fl_valid = 0;
        dif.fl_instr = 0; dif.fl_npc = 0; dif.wb_wen = 0; dif.wb_sel = 0; dif.wb_data = 0;

        // Reset, then idle with ihit low.
        cyc(1, 0, 0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
        cyc(1, 1, 0, 0, 1, i_addiu, 1, 5'd1, 32'h55);
        @(posedge clk); #1;
        chk("rst_out_zero", 32'(|dif.out), 32'd0);
        chk("rst_hazard", 32'(dif.hazard), 32'd0);
        cyc(0, 0, 0, 0, 1, i_addiu, 0, 5'd0, 32'd0);

        // ADDIU $2,$1,-1 with $1=5.
        cyc(0, 0, 0, 0, 0, 32'd0, 1, 5'd1, 32'd5);
        cyc(0, 1, 0, 0, 1, i_addiu, 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("addiu_rdat1", dif.out.rdat1, 32'd5);
        chk("addiu_imm32", dif.out.imm32, 32'hFFFFFFFF);
        chk("addiu_wsel", 32'(dif.out.wsel), 32'd2);
        chk("addiu_regwen", 32'(dif.out.regwen), 32'd1);
        chk("addiu_alusrc", 32'(dif.out.alusrc), 32'd1);

        // Load-use: LW $3 then ADDU $4,$3,$2.
        cyc(0, 1, 0, 0, 1, i_lw, 0, 5'd0, 32'd0);
        cyc(0, 1, 0, 0, 1, i_addu4, 0, 5'd0, 32'd0);
        #2 chk("lu_hazard", 32'(dif.hazard), 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble", 32'(dif.out.valid), 32'd0);
        cyc(0, 1, 0, 0, 1, i_addu4, 0, 5'd0, 32'd0);
        #2 chk("lu_clear", 32'(dif.hazard), 32'd0);
        @(posedge clk); #1;
        chk("lu_addu_wsel", 32'(dif.out.wsel), 32'd4);

        // Load-use coinciding with flush.
        cyc(0, 1, 0, 0, 1, i_lw, 0, 5'd0, 32'd0);
        cyc(0, 1, 0, 1, 1, i_addu4, 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("flush_bubble", 32'(dif.out.valid), 32'd0);
        cyc(0, 1, 0, 0, 1, i_addu4, 0, 5'd0, 32'd0);
        #2 chk("flush_no_stall", 32'(dif.hazard), 32'd0);

        // Downstream stall holds the latch.
        cyc(0, 1, 0, 0, 1, i_addiu, 0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0, 1, rand_instr(), 0, 5'd0, 32'd0);
            @(posedge clk); #1;
            chk("stall_hold_wsel", 32'(dif.out.wsel), 32'd2);
        end
        cyc(0, 1, 0, 0, 1, i_ori, 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("stall_release_imm", dif.out.imm32, 32'h000000F0);

        // Writeback overlapping decode, and a write to r0.
        cyc(0, 0, 0, 0, 0, 32'd0, 1, 5'd5, 32'h00001234);
        cyc(0, 1, 0, 0, 1, i_addu6, 1, 5'd5, 32'hDEADBEEF);
`ifdef FORWARD_WB_EN
        fwd_exp = 32'hDEADBEEF;
`else
        fwd_exp = 32'h00001234;
`endif
        @(posedge clk); #1;
        chk("wb_overlap_rdat1", dif.out.rdat1, fwd_exp);
        cyc(0, 0, 0, 0, 0, 32'd0, 1, 5'd0, 32'hFFFFFFFF);
        cyc(0, 1, 0, 0, 1, i_addu7, 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("r0_rdat1", dif.out.rdat1, 32'd0);
        chk("r0_rdat2", dif.out.rdat2, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, rand_instr(),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        @(posedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
